// File: rtl/fpga_ccff_loader.sv
// Wishbone-slave bitstream loader: buffers 32-bit words in a 4-deep FIFO and
// shifts them LSB-first into the FPGA configuration chain on a divided prog clock.
module fpga_ccff_loader #(
  parameter int CNT_W   = 20,
  parameter int CLK_DIV = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        ccff_tail_i,
  output logic        prog_clk_o,
  output logic        ccff_head_o,
  output logic        busy_o
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LOW   = 2'd2;
  localparam logic [1:0] S_HIGH  = 2'd3;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [1:0]       state;
  logic [7:0]       div_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] len_q;
  logic [4:0]       bit_idx;
  logic [31:0]      shift_q;
  logic [31:0]      tail_q;
  logic [31:0]      rd_data;
  logic             start_q;
  logic             abort_q;
  logic             done_q;
  logic             ovf_q;
  logic [31:0]      fifo_mem [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [2:0]       level;

  logic       wb_req;
  logic       wr_en;
  logic [2:0] reg_sel;
  logic       data_wr;
  logic       status_wr;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       fifo_push;
  logic       bit_end;
  logic       unused_adr;

  assign wb_req     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr_en      = wb_req & wbs_we_i;
  assign reg_sel    = wbs_adr_i[4:2];
  assign unused_adr = &{1'b0, wbs_adr_i[31:5], wbs_adr_i[1:0]};
  assign data_wr    = wr_en && (reg_sel == 3'd2);
  assign status_wr  = wr_en && (reg_sel == 3'd3);
  assign fifo_full  = (level == 3'd4);
  assign fifo_empty = (level == 3'd0);
  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign fifo_pop   = (state == S_FETCH) && !fifo_empty && !abort_q;
  assign fifo_push  = data_wr && (!fifo_full || fifo_pop);
  assign bit_end    = (state == S_HIGH) && (div_cnt == DIV_LAST) && !abort_q;
  assign busy_o     = (state != S_IDLE);

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      3'd1:    rd_data = 32'(len_q);
      3'd3:    rd_data = {25'd0, level, 1'b0, ovf_q, done_q, busy_o};
      3'd4:    rd_data = tail_q;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
      len_q     <= '0;
    end else begin
      wbs_ack_o <= wb_req;
      wbs_dat_o <= (wb_req && !wbs_we_i) ? rd_data : '0;
      start_q   <= wr_en && (reg_sel == 3'd0) && wbs_dat_i[0];
      abort_q   <= wr_en && (reg_sel == 3'd0) && wbs_dat_i[1];
      if (wr_en && (reg_sel == 3'd1)) len_q <= wbs_dat_i[CNT_W-1:0];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (fifo_push) fifo_mem[wr_ptr] <= wbs_dat_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (abort_q) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 2'd1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({fifo_push, fifo_pop})
        2'b10:   level <= level + 3'd1;
        2'b01:   level <= level - 3'd1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (fifo_pop)     shift_q <= fifo_mem[rd_ptr];
    else if (bit_end) shift_q <= {1'b0, shift_q[31:1]};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= S_IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      prog_clk_o  <= 1'b0;
      ccff_head_o <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      tail_q      <= '0;
    end else begin
      if (data_wr && fifo_full && !fifo_pop)  ovf_q <= 1'b1;
      else if (status_wr && wbs_dat_i[2])     ovf_q <= 1'b0;
      if (status_wr && wbs_dat_i[1])          done_q <= 1'b0;

      if (abort_q) begin
        state       <= S_IDLE;
        div_cnt     <= '0;
        prog_clk_o  <= 1'b0;
        ccff_head_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_q) begin
              if (len_q != '0) begin
                bit_cnt <= len_q;
                state   <= S_FETCH;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          S_FETCH: begin
            if (!fifo_empty) begin
              ccff_head_o <= fifo_mem[rd_ptr][0];
              bit_idx     <= '0;
              div_cnt     <= '0;
              state       <= S_LOW;
            end
          end
          S_LOW: begin
            if (div_cnt == DIV_LAST) begin
              div_cnt    <= '0;
              prog_clk_o <= 1'b1;
              state      <= S_HIGH;
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
          default: begin
            if (div_cnt == 8'd0) tail_q <= {tail_q[30:0], ccff_tail_i};
            if (div_cnt == DIV_LAST) begin
              div_cnt    <= '0;
              prog_clk_o <= 1'b0;
              bit_idx    <= bit_idx + 5'd1;
              if (bit_cnt != '0) bit_cnt <= bit_cnt - CNT_W'(1);
              // Finishing mid-word leaves the rest of that word and later FIFO words unused.
              if (bit_cnt <= CNT_W'(1)) begin
                state  <= S_IDLE;
                done_q <= 1'b1;
              end else if (bit_idx == 5'd31) begin
                state <= S_FETCH;
              end else begin
                ccff_head_o <= shift_q[1];
                state       <= S_LOW;
              end
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: doc/fpga_ccff_loader.md
# fpga_ccff_loader

Wishbone-slave bitstream loader for the configuration-chain (CCFF) input of `fpga_core`. Firmware writes 32-bit bitstream words into a 4-entry FIFO, and the block serializes them LSB-first onto `ccff_head_o`. It generates `prog_clk_o` by division of the Wishbone clock and captures `ccff_tail_i` for readback. The block sits in the user area directly upstream of the FPGA core's configuration chain and replaces externally bit-banged pad loading.

## Interface
Parameters:
- `CNT_W`, default 20: width of the bit-length counter; maximum bitstream length is 2^CNT_W-1 bits.
- `CLK_DIV`, default 2: `prog_clk_o` half-period in `wb_clk_i` cycles; legal range 1..255.

Ports:
- `wb_clk_i`, input, 1: the single clock.
- `wb_rst_ni`, input, 1: asynchronous, active-low reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`, inputs, 1 each: Wishbone strobe, cycle and write-enable.
- `wbs_adr_i`, input, 32: byte address; only bits [4:2] are decoded.
- `wbs_dat_i`, input, 32: write data. `wbs_sel_i` is ignored and every access is a full word.
- `wbs_ack_o`, output, 1: Wishbone acknowledge.
- `wbs_dat_o`, output, 32: read data.
- `ccff_tail_i`, input, 1: end of the configuration chain.
- `prog_clk_o`, output, 1: configuration clock to the FPGA.
- `ccff_head_o`, output, 1: serial configuration data to the FPGA.
- `busy_o`, output, 1: high while a load is in progress.

## Operation
Register map (`wbs_adr_i[4:2]`):
- 0 CTRL, write-only:
  - bit0 START, self-clearing.
  - bit1 ABORT, self-clearing.
  - Reads return 0.
- 1 LEN, read/write: [CNT_W-1:0] is the total number of bits to shift.
- 2 DATA, write-only: pushes one word into the FIFO.
- 3 STATUS, read-only:
  - bit0 busy.
  - bit1 done, sticky.
  - bit2 ovf, sticky.
  - [6:4] FIFO level, 0..4.
  - Writing 1 to bit1 or bit2 clears that flag.
- 4 TAIL, read-only: 32-bit shift register of captured `ccff_tail_i` samples; the newest sample is in bit0.
- Addresses 5..7: reads return 0, writes are ignored.

FIFO:
- 4 deep, 32 bits wide.
- A DATA write when the FIFO is full drops the word and sets ovf.
- The write is still acked.
- ABORT and reset flush the FIFO.

State machine, states IDLE, FETCH, LOW, HIGH:
- IDLE:
  - START with LEN≠0 loads the bit counter from LEN and goes to FETCH.
  - START with LEN=0 sets done and stays in IDLE.
  - START while busy is ignored.
- FETCH:
  - If the FIFO is non-empty, pop one word into the 32-bit shift register, set the word-bit index to 0 and go to LOW.
  - If the FIFO is empty, stay in FETCH with `prog_clk_o` held low. This is a starvation stall; no bit is lost.
- LOW:
  - On entry, `ccff_head_o` = shift register bit0.
  - `prog_clk_o` is 0 for CLK_DIV cycles, then go to HIGH.
- HIGH:
  - `prog_clk_o` is 1 for CLK_DIV cycles.
  - On the first HIGH cycle, `ccff_tail_i` is shifted into TAIL.
  - On exit, the shift register shifts right, the bit counter decrements and the word-bit index increments.
  - Next state when the counter reaches 0: IDLE, with done set.
  - Next state when the word-bit index reaches 32: FETCH.
  - Otherwise, next state is LOW.
- Partial last word: only LEN mod 32 bits of the final word are shifted. Unused upper bits are discarded, and any words remaining in the FIFO stay there.
- ABORT from any state: IDLE, FIFO flushed, `prog_clk_o`=0, `ccff_head_o`=0, done not set.
- `busy_o` = (state≠IDLE).

Arithmetic:
- The bit counter is CNT_W bits wide and never wraps; decrement happens only when the counter is non-zero.
- The half-period counter is 8 bits wide.

## Timing
- Reset values:
  - `prog_clk_o`=0, `ccff_head_o`=0, `busy_o`=0, `wbs_ack_o`=0, `wbs_dat_o`=0.
  - LEN=0, TAIL=0, done=0, ovf=0, FIFO empty, state IDLE.
- Wishbone:
  - `wbs_ack_o` is high for exactly one cycle, in the cycle after `stb&cyc` is sampled with ack low.
  - Ack is never asserted on back-to-back cycles.
  - Read data is valid in the ack cycle.
  - The register write takes effect on the ack edge.
- START/LEN: START is acted on in the cycle after its ack, so the first LOW begins at ack+2 cycles if the FIFO is non-empty.
- Bit period: 2*CLK_DIV cycles.
  - `ccff_head_o` is stable for the whole period and changes only on LOW entry.
  - The FETCH between words adds exactly 1 low cycle.
- Last bit: busy falls and done rises in the same cycle that `prog_clk_o` returns to 0.
- Simultaneous DATA write and FETCH pop when the FIFO is full: the pop takes precedence and the write is accepted, with no ovf.
- Reset mid-shift: all outputs drop immediately (asynchronous) to their reset values.

## Test plan
- Single word:
  - Stimulus: LEN=8, DATA=0x000000A5, START, CLK_DIV=2.
  - Required: `ccff_head_o` sequence 1,0,1,0,0,1,0,1.
  - Required: 8 `prog_clk_o` rising edges, each 4 cycles apart.
  - Required: done=1, FIFO level 0.
- Multi-word with partial last word:
  - Stimulus: LEN=40, DATA words 0xFFFFFFFF and 0x00000003, START.
  - Required: 32 ones followed by 1,1,0,0,0,0,0,0.
  - Required: exactly 40 edges and exactly one extra low cycle between the two words.
- Starvation stall:
  - Stimulus: LEN=64, one word written, START; the second word is written 50 cycles after the first 32 bits complete.
  - Required: `prog_clk_o` stays 0 and busy stays 1 during the gap; the total edge count is 64.
- Overflow:
  - Stimulus: five DATA writes while IDLE.
  - Required: all five writes acked; STATUS shows level=4, ovf=1.
  - Required: writing STATUS=0x4 clears ovf.
- Abort and reset mid-shift:
  - Stimulus: ABORT after 10 bits.
  - Required: IDLE, level=0, done=0, `prog_clk_o`=0.
  - Stimulus: `wb_rst_ni` asserted low mid-shift.
  - Required: all outputs 0 within the same cycle.
- Readback and edge cases:
  - Stimulus: loop `ccff_head_o` to `ccff_tail_i` with 1 bit of delay, LEN=32, DATA=0x12345678.
  - Required: TAIL equals the bit-reversed stream as captured.
  - Stimulus: START with LEN=0.
  - Required: done=1 with no `prog_clk_o` edges.
  - Stimulus: START while busy.
  - Required: ignored.
